// File: rtl/screen_pkg.sv
// Shared widths, screen geometry and encodings for the screen RAM arbiter.
package screen_pkg;

  localparam int unsigned ADDR_W_DEF   = 8;
  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned SCREEN_BYTES = 256;
  localparam int unsigned CNT_W        = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_CLEAR   = 2'd3
  } state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_BR  = 1'b1
  } grant_t;

endpackage

// File: rtl/screen_rr_pick.sv
// Two-requester round-robin picker; remembers the last granted side.
module screen_rr_pick
  import screen_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   req_cpu,
  input  logic   req_br,
  input  logic   take,
  output logic   any_c,
  output grant_t win_c
);

  grant_t last_q;

  // On a tie the side not served last time wins.
  always_comb begin
    any_c = req_cpu | req_br;
    win_c = GNT_CPU;
    if (req_cpu && req_br) begin
      win_c = (last_q == GNT_CPU) ? GNT_BR : GNT_CPU;
    end else if (req_br) begin
      win_c = GNT_BR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= GNT_CPU;
    end else if (take && any_c) begin
      last_q <= win_c;
    end
  end

endmodule

// File: rtl/screen_arbiter.sv
// Arbitrates CPU and display-bridge access to the screen RAM and runs
// a full-screen clear that outranks both requesters.
module screen_arbiter
  import screen_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              cpu_clear,
  output logic              cpu_clear_done,
  input  logic              br_read,
  input  logic [ADDR_W-1:0] br_idx,
  output logic [DATA_W-1:0] br_byte,
  output logic              br_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCREEN_BYTES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  grant_t            acc_who_q, acc_who_d;
  logic              acc_we_q, acc_we_d;

  logic              done_d, cpu_ack_d, br_ack_d;
  logic [DATA_W-1:0] cpu_rdata_d, br_byte_d;
  logic              mem_en_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;

  logic              take;
  logic              pick_any_c;
  grant_t            pick_win_c;

  // A requester whose ack is up this cycle is not regranted.
  screen_rr_pick u_pick (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_cpu (cpu_req & ~cpu_ack),
    .req_br  (br_read & ~br_ack),
    .take    (take),
    .any_c   (pick_any_c),
    .win_c   (pick_win_c)
  );

  // Next-state and next-output logic; RAM controls are registered so they
  // line up with the state they belong to.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    acc_who_d   = acc_who_q;
    acc_we_d    = acc_we_q;
    done_d      = 1'b0;
    cpu_ack_d   = 1'b0;
    br_ack_d    = 1'b0;
    cpu_rdata_d = cpu_rdata;
    br_byte_d   = br_byte;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    take        = 1'b0;

    if (cpu_clear && !pend_q) begin
      pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          state_d     = ST_CLEAR;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = ADDR_W'(cnt_q);
          mem_wdata_d = '0;
        end else if (pick_any_c) begin
          take      = 1'b1;
          state_d   = ST_ACCESS;
          acc_who_d = pick_win_c;
          mem_en_d  = 1'b1;
          if (pick_win_c == GNT_CPU) begin
            acc_we_d    = cpu_we;
            mem_we_d    = cpu_we;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
          end else begin
            acc_we_d    = 1'b0;
            mem_addr_d  = br_idx;
            mem_wdata_d = '0;
          end
        end
      end
      ST_ACCESS: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_d = ST_IDLE;
        if (acc_who_q == GNT_CPU) begin
          cpu_ack_d = 1'b1;
          if (!acc_we_q) begin
            cpu_rdata_d = mem_rdata;
          end
        end else begin
          br_ack_d  = 1'b1;
          br_byte_d = mem_rdata;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          done_d  = 1'b1;
          pend_d  = 1'b0;
        end else begin
          cnt_d       = cnt_q + CNT_W'(1);
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = ADDR_W'(cnt_q + CNT_W'(1));
          mem_wdata_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      pend_q         <= 1'b0;
      acc_who_q      <= GNT_CPU;
      acc_we_q       <= 1'b0;
      cpu_clear_done <= 1'b0;
      cpu_ack        <= 1'b0;
      br_ack         <= 1'b0;
      cpu_rdata      <= '0;
      br_byte        <= '0;
      mem_en         <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pend_q         <= pend_d;
      acc_who_q      <= acc_who_d;
      acc_we_q       <= acc_we_d;
      cpu_clear_done <= done_d;
      cpu_ack        <= cpu_ack_d;
      br_ack         <= br_ack_d;
      cpu_rdata      <= cpu_rdata_d;
      br_byte        <= br_byte_d;
      mem_en         <= mem_en_d;
      mem_we         <= mem_we_d;
      mem_addr       <= mem_addr_d;
      mem_wdata      <= mem_wdata_d;
    end
  end

  assign busy = pend_q;

endmodule

// File: tb/tb_screen_arbiter.sv
// Directed bench for screen_arbiter with a behavioural 256-byte screen RAM.
module tb_screen_arbiter;

  localparam int BOUND = 60;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_req, cpu_we, cpu_clear, br_read;
  logic [7:0] cpu_addr, cpu_wdata, br_idx;
  logic [7:0] cpu_rdata, br_byte, mem_addr, mem_wdata, mem_rdata;
  logic       cpu_ack, cpu_clear_done, br_ack, mem_en, mem_we, busy;

  int n_vec;
  int n_err;

  screen_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_req        (cpu_req),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_rdata      (cpu_rdata),
    .cpu_ack        (cpu_ack),
    .cpu_clear      (cpu_clear),
    .cpu_clear_done (cpu_clear_done),
    .br_read        (br_read),
    .br_idx         (br_idx),
    .br_byte        (br_byte),
    .br_ack         (br_ack),
    .mem_en         (mem_en),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Screen RAM: loaded on the first edge, one-cycle read latency.
  logic [7:0] ram [256];
  logic       loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) ram[i] <= (i == 'h12) ? 8'hA5 : (8'(i) ^ 8'h5A);
      loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic br_op(input logic [7:0] a, output int lat, output logic [7:0] b);
    @(negedge clk);
    br_read = 1'b1;
    br_idx  = a;
    lat     = 0;
    b       = '0;
    while (lat < BOUND) begin
      @(negedge clk);
      lat++;
      if (br_ack) begin
        b = br_byte;
        break;
      end
    end
    br_read = 1'b0;
  endtask

  task automatic cpu_op(input logic we, input logic [7:0] a, input logic [7:0] wd,
                        output int lat, output logic [7:0] rd, output int nwr,
                        output logic [7:0] wr_addr);
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = wd;
    lat       = 0;
    nwr       = 0;
    wr_addr   = '0;
    while (lat < BOUND) begin
      @(negedge clk);
      lat++;
      if (mem_en && mem_we) begin
        nwr++;
        wr_addr = mem_addr;
      end
      if (cpu_ack) break;
    end
    rd      = cpu_rdata;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
  endtask

  // Per-cycle observation across a clear, optionally pulsing cpu_clear again.
  int         w_nwr, w_first, w_last, w_ndone, w_done_at, w_seq_bad, w_cpu_at, w_br_at;
  logic       w_busy_done, w_busy_pre;
  logic [7:0] w_br_b;

  task automatic watch(input int ncyc, input int clr2_at);
    logic prev_busy;
    w_nwr = 0; w_first = -1; w_last = -1; w_ndone = 0; w_done_at = -1;
    w_seq_bad = 0; w_cpu_at = -1; w_br_at = -1; w_br_b = '0;
    w_busy_done = 1'b1; w_busy_pre = 1'b0;
    prev_busy = busy;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      cpu_clear = (c == clr2_at);
      if (mem_en && mem_we && mem_wdata == 8'h00) begin
        if (mem_addr != 8'(w_nwr)) w_seq_bad++;
        if (w_nwr == 0) w_first = c;
        w_last = c;
        w_nwr++;
      end
      if (cpu_clear_done) begin
        w_ndone++;
        w_done_at   = c;
        w_busy_done = busy;
        w_busy_pre  = prev_busy;
      end
      if (cpu_ack) begin
        w_cpu_at = c;
        cpu_req  = 1'b0;
      end
      if (br_ack) begin
        w_br_at = c;
        w_br_b  = br_byte;
        br_read = 1'b0;
      end
      prev_busy = busy;
    end
    cpu_clear = 1'b0;
  endtask

  int         lat, nwr, na, seen, nd;
  logic [7:0] rd, waddr;
  logic [1:0] ack_who [4];
  int         ack_at  [4];

  initial begin
    n_vec = 0; n_err = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    cpu_clear = 0; br_read = 0; br_idx = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_acks",    32'({cpu_ack, br_ack, cpu_clear_done}), 0);
    chk("rst_mem_ctl", 32'({mem_en, mem_we}), 0);
    chk("rst_busy",    32'(busy), 0);
    chk("rst_rdata",   32'({cpu_rdata, br_byte}), 0);
    chk("rst_mem_bus", 32'({mem_addr, mem_wdata}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_mem_en", 32'(mem_en), 0);

    // bridge read of a known byte
    br_op(8'h12, lat, rd);
    chk("br_lat",  32'(lat), 3);
    chk("br_byte", 32'(rd), 'hA5);

    // CPU read, write, read back
    cpu_op(1'b0, 8'h05, 8'h00, lat, rd, nwr, waddr);
    chk("cpu_rd_lat",  32'(lat), 3);
    chk("cpu_rd_data", 32'(rd), 'h5F);
    cpu_op(1'b1, 8'h40, 8'h3C, lat, rd, nwr, waddr);
    chk("cpu_wr_lat",  32'(lat), 3);
    chk("cpu_wr_nwr",  32'(nwr), 1);
    chk("cpu_wr_addr", 32'(waddr), 'h40);
    chk("cpu_wr_hold", 32'(rd), 'h5F);
    cpu_op(1'b0, 8'h40, 8'h00, lat, rd, nwr, waddr);
    chk("cpu_rb_lat",  32'(lat), 3);
    chk("cpu_rb_data", 32'(rd), 'h3C);
    chk("cpu_rb_nwr",  32'(nwr), 0);

    // both held: bridge first on the tie, then alternate every 3 cycles
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
    br_read = 1'b1; br_idx = 8'h12;
    na = 0;
    for (int i = 0; i < 4; i++) begin ack_who[i] = '0; ack_at[i] = 0; end
    for (int c = 1; c <= 40 && na < 4; c++) begin
      @(negedge clk);
      if (br_ack || cpu_ack) begin
        ack_who[na] = {cpu_ack, br_ack};
        ack_at[na]  = c;
        na++;
      end
    end
    cpu_req = 1'b0; br_read = 1'b0;
    chk("alt_count", 32'(na), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("alt_who%0d", i), 32'(ack_who[i]), (i % 2 == 0) ? 1 : 2);
      chk($sformatf("alt_at%0d", i),  32'(ack_at[i]), 32'(3 * (i + 1)));
    end

    // reset in the middle of a clear
    @(negedge clk); cpu_clear = 1'b1;
    @(negedge clk); cpu_clear = 1'b0;
    seen = 0; nd = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (cpu_clear_done) nd++;
      if (mem_en && mem_we && mem_addr == 8'd100) begin
        seen = 1;
        break;
      end
    end
    chk("rstclr_reached", 32'(seen), 1);
    rst_n = 1'b0;
    #1;
    chk("rstclr_busy",   32'(busy), 0);
    chk("rstclr_mem_en", 32'(mem_en), 0);
    repeat (2) @(negedge clk);
    chk("rstclr_done",   32'(nd + int'(cpu_clear_done)), 0);
    rst_n = 1'b1;
    br_op(8'hC8, lat, rd);
    chk("rstclr_br_lat",   32'(lat), 3);
    chk("rstclr_unzeroed", 32'(rd), 'h92);
    cpu_op(1'b0, 8'd50, 8'h00, lat, rd, nwr, waddr);
    chk("rstclr_zeroed",   32'(rd), 0);

    // clear outranks a pending bridge read
    @(negedge clk); cpu_clear = 1'b1;
    @(negedge clk); cpu_clear = 1'b0; br_read = 1'b1; br_idx = 8'hC8;
    chk("clr_busy_rise", 32'(busy), 1);
    watch(300, 0);
    chk("clr_nwr",       32'(w_nwr), 256);
    chk("clr_seq",       32'(w_seq_bad), 0);
    chk("clr_first",     32'(w_first), 1);
    chk("clr_last",      32'(w_last), 256);
    chk("clr_done_at",   32'(w_done_at), 257);
    chk("clr_ndone",     32'(w_ndone), 1);
    chk("clr_busy_fall", 32'({w_busy_pre, w_busy_done}), 'b10);
    chk("clr_br_at",     32'(w_br_at), 260);
    chk("clr_br_byte",   32'(w_br_b), 0);

    // clear during a CPU access, plus a second clear while busy
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h80; cpu_wdata = 8'h77;
    @(negedge clk);
    chk("acc_bus", 32'({mem_en, mem_we, mem_addr, mem_wdata}), 'h38077);
    cpu_clear = 1'b1;
    @(negedge clk);
    cpu_clear = 1'b0;
    chk("acc_busy", 32'(busy), 1);
    watch(400, 8);
    cpu_we = 1'b0;
    chk("acc_ack_at",  32'(w_cpu_at), 1);
    chk("acc_first",   32'(w_first), 2);
    chk("acc_nwr",     32'(w_nwr), 256);
    chk("acc_done_at", 32'(w_done_at), 258);
    chk("acc_ndone",   32'(w_ndone), 1);
    cpu_op(1'b0, 8'h80, 8'h00, lat, rd, nwr, waddr);
    chk("acc_cleared", 32'(rd), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
